// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - segment geometry helpers for the carry-segmented add/sub pipeline
package addsub_pkg;

    function automatic int seg_w(input int width, input int segs);
        return (width + segs - 1) / segs;
    endfunction

    function automatic int top_w(input int width, input int segs);
        return width - (segs - 1) * seg_w(width, segs);
    endfunction

    function automatic int seg_width(input int width, input int segs, input int k);
        return (k == segs - 1) ? top_w(width, segs) : seg_w(width, segs);
    endfunction

    // Operand bits still waiting for their stage after stage k has taken its slice
    function automatic int upper_w(input int width, input int segs, input int k);
        return width - (k + 1) * seg_w(width, segs);
    endfunction

    function automatic int low_w(input int width, input int segs, input int k);
        return k * seg_w(width, segs);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - one registered carry segment: sum, carry out and carry into its MSB
module addsub_seg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);
    logic [W:0]   w_full;
    logic         w_cmsb;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_cmsb;

    assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // Carry into the MSB recovered from the MSB sum bit, so W = 1 needs no special case
    assign w_cmsb = a[W-1] ^ b[W-1] ^ w_full[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_cmsb <= 1'b0;
        end else if (en) begin
            r_sum  <= w_full[W-1:0];
            r_cout <= w_full[W];
            r_cmsb <= w_cmsb;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign cmsb = r_cmsb;

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined two's complement adder/subtractor, SEGS carry segments,
// operand skew and result deskew registers, optional signed saturation, valid/ready stream
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 50,
    parameter int SEGS   = 2,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);
    localparam int SW = seg_w(WIDTH, SEGS);
    localparam int TW = top_w(WIDTH, SEGS);

    logic             w_en;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_res;
    logic             w_top_cout;
    logic             w_top_cmsb;
    logic             w_ovf;
    logic [SEGS-1:0]  r_vld;
    logic             r_amsb;

    assign out_valid = r_vld[SEGS-1];
    assign w_en      = out_ready | ~out_valid;
    assign in_ready  = w_en;
    // Subtraction is a + ~b + 1; the +1 enters as the carry-in of stage 0
    assign w_bx      = op_sub ? ~in_b : in_b;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        localparam int KW = seg_width(WIDTH, SEGS, k);
        logic [KW-1:0] w_a;
        logic [KW-1:0] w_b;
        logic [KW-1:0] w_sum;
        logic          w_cin;
        logic          w_cout;

        if (k == 0) begin : g_src
            assign w_a   = in_a[KW-1:0];
            assign w_b   = w_bx[KW-1:0];
            assign w_cin = op_sub;
        end else begin : g_src
            assign w_a   = g_stage[k-1].g_up.r_ua[KW-1:0];
            assign w_b   = g_stage[k-1].g_up.r_ub[KW-1:0];
            assign w_cin = g_stage[k-1].w_cout;
        end

        if (k == SEGS - 1) begin : g_seg
            addsub_seg #(.W(KW)) u_seg (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (w_en),
                .a    (w_a),
                .b    (w_b),
                .cin  (w_cin),
                .sum  (w_sum),
                .cout (w_cout),
                .cmsb (w_top_cmsb)
            );
            assign w_top_cout = w_cout;
        end else begin : g_seg
            logic w_cmsb_unused;
            addsub_seg #(.W(KW)) u_seg (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (w_en),
                .a    (w_a),
                .b    (w_b),
                .cin  (w_cin),
                .sum  (w_sum),
                .cout (w_cout),
                .cmsb (w_cmsb_unused)
            );
        end

        if (k < SEGS - 1) begin : g_up
            localparam int UW = upper_w(WIDTH, SEGS, k);
            logic [UW-1:0] w_ua_nxt;
            logic [UW-1:0] w_ub_nxt;
            logic [UW-1:0] r_ua;
            logic [UW-1:0] r_ub;

            if (k == 0) begin : g_nxt
                assign w_ua_nxt = in_a[WIDTH-1:SW];
                assign w_ub_nxt = w_bx[WIDTH-1:SW];
            end else begin : g_nxt
                assign w_ua_nxt = g_stage[k-1].g_up.r_ua[UW+SW-1:SW];
                assign w_ub_nxt = g_stage[k-1].g_up.r_ub[UW+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ua <= '0;
                    r_ub <= '0;
                end else if (w_en) begin
                    r_ua <= w_ua_nxt;
                    r_ub <= w_ub_nxt;
                end
            end
        end

        if (k > 0) begin : g_low
            localparam int LW = low_w(WIDTH, SEGS, k);
            logic [LW-1:0] w_low_nxt;
            logic [LW-1:0] r_low;

            if (k == 1) begin : g_nxt
                assign w_low_nxt = g_stage[0].w_sum;
            end else begin : g_nxt
                assign w_low_nxt = {g_stage[k-1].w_sum, g_stage[k-1].g_low.r_low};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_low <= '0;
                end else if (w_en) begin
                    r_low <= w_low_nxt;
                end
            end
        end
    end

    if (SEGS == 1) begin : g_res
        assign w_res = g_stage[0].w_sum;
    end else begin : g_res
        assign w_res = {g_stage[SEGS-1].w_sum, g_stage[SEGS-1].g_low.r_low};
    end

    // The sign of a travels with the top segment and picks the clamp direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_amsb <= 1'b0;
        end else if (w_en) begin
            r_vld  <= (r_vld << 1) | SEGS'(in_valid);
            r_amsb <= g_stage[SEGS-1].w_a[TW-1];
        end
    end

    assign w_ovf   = w_top_cmsb ^ w_top_cout;
    assign out_ovf = w_ovf & out_valid;

    always_comb begin
        out_data = w_res;
        if (SAT_EN && w_ovf) begin
            out_data = r_amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed and random checks of addsub_pipe across five parameter sets
module tb_addsub_pipe;
    localparam int N = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        op_sub;
    logic [49:0] in_a;
    logic [49:0] in_b;
    logic        out_ready;

    logic        r0, r1, r2, r3, r4;
    logic        v0, v1, v2, v3, v4;
    logic        o0, o1, o2, o3, o4;
    logic [49:0] d0, d1, d2, d3;
    logic [7:0]  d4;

    logic [N-1:0] m_irdy;
    logic [N-1:0] m_ovld;
    logic [N-1:0] m_ovf;
    logic [49:0]  m_odata [N];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [50:0] sb_mem [N][64];
    int          sb_wr [N];
    int          sb_rd [N];

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(50), .SEGS(2), .SAT_EN(1'b1)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .op_sub(op_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_ovf(o0));
    addsub_pipe #(.WIDTH(50), .SEGS(2), .SAT_EN(1'b0)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .op_sub(op_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_ovf(o1));
    addsub_pipe #(.WIDTH(50), .SEGS(1), .SAT_EN(1'b1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .op_sub(op_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_ovf(o2));
    addsub_pipe #(.WIDTH(50), .SEGS(3), .SAT_EN(1'b0)) u_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3), .op_sub(op_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(v3), .out_ready(out_ready), .out_data(d3), .out_ovf(o3));
    addsub_pipe #(.WIDTH(8), .SEGS(8), .SAT_EN(1'b1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4), .op_sub(op_sub),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_ovf(o4));

    assign m_irdy = {r4, r3, r2, r1, r0};
    assign m_ovld = {v4, v3, v2, v1, v0};
    assign m_ovf  = {o4, o3, o2, o1, o0};

    always_comb begin
        m_odata[0] = d0;
        m_odata[1] = d1;
        m_odata[2] = d2;
        m_odata[3] = d3;
        m_odata[4] = {42'b0, d4};
    end

    function automatic int width_of(input int i);
        return (i == 4) ? 8 : 50;
    endfunction

    function automatic int sat_of(input int i);
        return (i == 1 || i == 3) ? 0 : 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [50:0] model(input logic [49:0] a, input logic [49:0] b,
                                          input logic sub, input int w, input int sat);
        longint sa, sbv, r, mx, mn, mask;
        logic   ovf;
        sa   = longint'(a) << (64 - w);
        sa   = sa >>> (64 - w);
        sbv  = longint'(b) << (64 - w);
        sbv  = sbv >>> (64 - w);
        mx   = (longint'(1) << (w - 1)) - 1;
        mn   = -mx - 1;
        mask = (longint'(1) << w) - 1;
        r    = sub ? sa - sbv : sa + sbv;
        ovf  = (r > mx) || (r < mn);
        if (ovf && sat != 0) r = (r > mx) ? mx : mn;
        r = r & mask;
        return {ovf, r[49:0]};
    endfunction

    function automatic logic [49:0] rand_op();
        logic [63:0] x;
        x = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return 50'h1FFFFFFFFFFFF;
            1:       return 50'h2000000000000;
            2:       return 50'h000000000007F;
            3:       return 50'h0000000000080;
            4:       return {25'h0, x[24:0]};
            default: return x[49:0];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every DUT's accepted beats against the arithmetic model, in order
    initial begin
        logic [50:0] e_v;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    sb_wr[i] = 0;
                    sb_rd[i] = 0;
                end else begin
                    if (m_ovld[i] && out_ready) begin
                        check($sformatf("sb%0d_pending", i), 64'(sb_wr[i] > sb_rd[i]), 64'd1);
                        if (sb_wr[i] > sb_rd[i]) begin
                            e_v = sb_mem[i][sb_rd[i] % 64];
                            check($sformatf("sb%0d_data", i), 64'(m_odata[i]), 64'(e_v[49:0]));
                            check($sformatf("sb%0d_ovf", i), 64'(m_ovf[i]), 64'(e_v[50]));
                            sb_rd[i]++;
                        end
                    end
                    if (in_valid && m_irdy[i]) begin
                        sb_mem[i][sb_wr[i] % 64] = model(in_a, in_b, op_sub, width_of(i), sat_of(i));
                        sb_wr[i]++;
                    end
                end
            end
        end
    end

    task automatic vec(input string tag, input logic [49:0] a, input logic [49:0] b, input logic sub,
                       input logic [49:0] e_sat, input logic e_ovf, input logic [49:0] e_wrap);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        op_sub   = sub;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(r0), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, 64'(v0), 64'd0);
        check({tag, "_s1_valid"}, 64'(v2), 64'd1);
        check({tag, "_s1_data"}, 64'(d2), 64'(e_sat));
        @(negedge clk);
        check({tag, "_lat2_valid"}, 64'(v0), 64'd1);
        check({tag, "_sat_data"}, 64'(d0), 64'(e_sat));
        check({tag, "_sat_ovf"}, 64'(o0), 64'(e_ovf));
        check({tag, "_wrap_data"}, 64'(d1), 64'(e_wrap));
        check({tag, "_wrap_ovf"}, 64'(o1), 64'(e_ovf));
        tick();
    endtask

    logic [49:0] bp_a [6];
    logic [49:0] bp_b [6];
    logic        bp_s [6];
    logic [49:0] bp_e [6];

    initial begin
        int          n_in;
        int          n_out;
        logic        held_v;
        logic [49:0] held_d;
        logic [N-1:0] seen;

        bp_a[0] = 50'd1;          bp_b[0] = 50'd2;         bp_s[0] = 1'b0; bp_e[0] = 50'd3;
        bp_a[1] = 50'd10;         bp_b[1] = 50'd3;         bp_s[1] = 1'b1; bp_e[1] = 50'd7;
        bp_a[2] = 50'h1FFFFFF;    bp_b[2] = 50'h1FFFFFF;   bp_s[2] = 1'b0; bp_e[2] = 50'h3FFFFFE;
        bp_a[3] = 50'd0;          bp_b[3] = 50'd1;         bp_s[3] = 1'b1; bp_e[3] = 50'h3FFFFFFFFFFFF;
        bp_a[4] = 50'd100;        bp_b[4] = 50'd100;       bp_s[4] = 1'b1; bp_e[4] = 50'd0;
        bp_a[5] = 50'h123456789;  bp_b[5] = 50'd1;         bp_s[5] = 1'b0; bp_e[5] = 50'h12345678A;

        rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(v0), 64'd0);
        check("rst_out_data", 64'(d0), 64'd0);
        check("rst_out_ovf", 64'(o0), 64'd0);
        check("rst_in_ready", 64'(r0), 64'd1);
        check("rst_valid_all", 64'(m_ovld), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        vec("cross", 50'h1FFFFFF, 50'd1, 1'b0, 50'h2000000, 1'b0, 50'h2000000);
        vec("neg", 50'd5, 50'd7, 1'b1, 50'h3FFFFFFFFFFFE, 1'b0, 50'h3FFFFFFFFFFFE);
        vec("povf", 50'h1FFFFFFFFFFFF, 50'd1, 1'b0, 50'h1FFFFFFFFFFFF, 1'b1, 50'h2000000000000);
        vec("novf", 50'h2000000000000, 50'd1, 1'b1, 50'h2000000000000, 1'b1, 50'h1FFFFFFFFFFFF);
        vec("m1m1", 50'h3FFFFFFFFFFFF, 50'h3FFFFFFFFFFFF, 1'b0, 50'h3FFFFFFFFFFFE, 1'b0, 50'h3FFFFFFFFFFFE);
        repeat (10) tick();

        n_in = 0; n_out = 0; held_v = 1'b0; held_d = '0;
        for (int c = 0; c < 40 && n_out < 6; c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (n_in < 6);
            if (n_in < 6) begin
                in_a   = bp_a[n_in];
                in_b   = bp_b[n_in];
                op_sub = bp_s[n_in];
            end
            @(negedge clk);
            if (!out_ready) begin
                check($sformatf("bp_in_ready_c%0d", c), 64'(r0), 64'd0);
                if (held_v) check($sformatf("bp_hold_c%0d", c), 64'(d0), 64'(held_d));
                held_v = 1'b1;
                held_d = d0;
            end else begin
                held_v = 1'b0;
            end
            if (v0 && out_ready && n_out < 6) begin
                check($sformatf("bp_out%0d", n_out), 64'(d0), 64'(bp_e[n_out]));
                n_out++;
            end
            if (in_valid && r0) n_in++;
            tick();
        end
        check("bp_count", 64'(n_out), 64'd6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();

        in_valid = 1'b1; in_a = 50'h1FFFFFFFFFFFF; in_b = 50'd1; op_sub = 1'b0;
        tick();
        in_a = 50'd40; in_b = 50'd2;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_valid", 64'(v0), 64'd0);
        check("mid_rst_data", 64'(d0), 64'd0);
        check("mid_rst_ovf", 64'(o0), 64'd0);
        check("mid_rst_valid_all", 64'(m_ovld), 64'd0);
        tick();
        rst_n = 1'b1;
        seen  = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            seen = seen | m_ovld;
            tick();
        end
        check("mid_rst_no_stale", 64'(seen), 64'd0);

        for (int n = 0; n < 300; n++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            op_sub    = 1'($urandom_range(0, 1));
            in_a      = rand_op();
            in_b      = rand_op();
            out_ready = ($urandom_range(0, 4) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("drain%0d", i), 64'(sb_wr[i] - sb_rd[i]), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, carry-segmented pipelined adder/subtractor. It is the successor to the fixed-width single-register adder in the math_blocks library.
- Splits the WIDTH-bit carry chain into SEGS registered segments so wide operands close timing at full clock rate.
- Adds a per-transaction add/sub select, optional signed saturation, an overflow flag and a valid/ready handshake.
- Used in the control-loop datapath in front of accumulators and PI blocks.

Parameters:
- WIDTH, 50, operand and result width in bits (two's complement), minimum 2.
- SEGS, 2, number of carry segments, which equals the pipeline latency; range 1..WIDTH.
- SAT_EN, 1, 1 = clamp on signed overflow; 0 = wrap (modular result).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- op_sub  in  1  0 = a+b, 1 = a-b; sampled with the beat
- in_a  in  WIDTH  operand a (signed)
- in_b  in  WIDTH  operand b (signed)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  result
- out_ovf  out  1  signed overflow occurred for this result, qualified by out_valid

Behaviour:
- Reset:
  - Clock and reset are one clock and an asynchronous active-low reset, exactly as decided.
  - rst_n low clears all valid bits, out_valid, out_data and out_ovf to 0 immediately.
  - In-flight beats are dropped and none are replayed after reset.
- Segmentation:
  - SEG_W = ceil(WIDTH/SEGS).
  - Segments 0..SEGS-2 are SEG_W bits wide; the top segment takes the remainder (WIDTH - (SEGS-1)*SEG_W bits, must be >=1).
- Stage k (k = 0..SEGS-1):
  - Adds segment k of a and b', where b' = op_sub ? ~b : b.
  - Carry-in is op_sub for k = 0, otherwise the registered carry-out of stage k-1.
- Skew registers:
  - Upper operand segments and op_sub are delayed so that each segment meets its carry.
  - Completed lower result segments are delayed so that all segments align at the output.
- Latency: exactly SEGS cycles from the accepted beat (in_valid & in_ready) to out_valid, when there is no stall. SEGS = 1 degenerates to a single registered add/sub.
- Handshake:
  - Global enable en = out_ready | ~out_valid.
  - in_ready = en, which is combinational from out_ready.
  - When en = 0, every pipeline register holds, and out_data/out_ovf stay stable while out_valid = 1.
  - Bubbles travel with the pipeline and are not compressed.
  - Throughput is 1 beat/cycle while out_ready = 1.
- Overflow, computed in the top segment: ovf = carry into MSB XOR carry out of MSB. The carry out of the MSB is discarded.
- Saturation:
  - If SAT_EN = 1 and ovf = 1: out_data = a_msb ? 100..0 (most negative) : 011..1 (most positive). a_msb is the delayed sign of operand a.
  - If SAT_EN = 0, the wrapped sum is output.
  - out_ovf reports overflow in both modes.
- Simultaneous accept and emit in the same cycle is legal and is the normal streaming case.
- Unused inputs when in_valid = 0 are don't-care; they must not alter out_data of valid beats.

Decomposition:
- Package addsub_pkg:
  - function seg_w(width, segs)
  - function top_w(width, segs)
  - localparam-generating helpers for the skew depths
- Sub-module addsub_seg (parameter W):
  - inputs en, a, b, cin
  - registered sum and cout, and carry into its MSB for the top instance
- addsub_pipe instantiates SEGS copies of addsub_seg with generate and adds the skew/deskew shift registers, the saturation mux and the valid chain.

Test Plan (WIDTH = 50, SEGS = 2, SEG_W = 25 unless noted):
- Add across the segment boundary: a = 0x1FFFFFF, b = 1, add -> out_data = 0x2000000, out_ovf = 0, out_valid exactly 2 cycles after accept.
- Subtract to a negative result: a = 5, b = 7, op_sub = 1 -> out_data = 0x3FFFFFFFFFFFE (-2), out_ovf = 0.
- Positive overflow, a = 0x1FFFFFFFFFFFF, b = 1, add:
  - SAT_EN = 1 -> out_data = 0x1FFFFFFFFFFFF, out_ovf = 1.
  - SAT_EN = 0 -> out_data = 0x2000000000000, out_ovf = 1.
  - Negative case: a = 0x2000000000000, b = 1, sub, SAT_EN = 1 -> out_data = 0x2000000000000, out_ovf = 1.
- Backpressure:
  - Stream 6 beats back-to-back with out_ready low for 3 cycles mid-stream.
  - Required: in_ready low during the stall, out_data held stable, all 6 results in order with no loss or duplication.
- Reset mid-flight: assert rst_n low for 1 cycle while 2 beats are in flight -> out_valid = 0 immediately, no stale result emitted afterwards.
- Parameter sweep with random operands checked against a reference model, including back-to-back mixed add/sub traffic:
  - SEGS = 1: latency 1.
  - SEGS = 3: segments 17/17/16.
  - WIDTH = 8, SEGS = 8.
